// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter: two Wishbone ports sharing two single-port SRAM banks,
// round-robin arbitration per bank with a one-deep ack pipeline.
module wb_ram_arbiter #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 4,
    parameter int WADDR_W = 8
) (
    input  logic               wb_clk,
    input  logic               wb_reset,
    input  logic               pA_wb_cyc_i,
    input  logic               pA_wb_stb_i,
    input  logic               pA_wb_we_i,
    input  logic [ADDR_W-1:0]  pA_wb_addr_i,
    input  logic [DATA_W-1:0]  pA_wb_data_i,
    input  logic [SEL_W-1:0]   pA_wb_sel_i,
    output logic               pA_wb_stall_o,
    output logic               pA_wb_ack_o,
    output logic [DATA_W-1:0]  pA_wb_data_o,
    input  logic               pB_wb_cyc_i,
    input  logic               pB_wb_stb_i,
    input  logic               pB_wb_we_i,
    input  logic [ADDR_W-1:0]  pB_wb_addr_i,
    input  logic [DATA_W-1:0]  pB_wb_data_i,
    input  logic [SEL_W-1:0]   pB_wb_sel_i,
    output logic               pB_wb_stall_o,
    output logic               pB_wb_ack_o,
    output logic [DATA_W-1:0]  pB_wb_data_o,
    output logic               b0_en_o,
    output logic [SEL_W-1:0]   b0_we_o,
    output logic [WADDR_W-1:0] b0_addr_o,
    output logic [DATA_W-1:0]  b0_din_o,
    input  logic [DATA_W-1:0]  b0_dout_i,
    output logic               b1_en_o,
    output logic [SEL_W-1:0]   b1_we_o,
    output logic [WADDR_W-1:0] b1_addr_o,
    output logic [DATA_W-1:0]  b1_din_o,
    input  logic [DATA_W-1:0]  b1_dout_i
);
    logic reqA, reqB, bankA, bankB, conflict, prioHit, grantA, grantB;
    logic useA0, useB0, useA1, useB1;
    logic ackA, ackB, ackBankA, ackBankB, ackWeA, ackWeB, prio0, prio1;
    logic [SEL_W-1:0] ackSelA, ackSelB, weA, weB;
    logic [WADDR_W-1:0] waA, waB;
    logic [DATA_W-1:0] rdA, rdB;
    logic unusedAddrBits;

    function automatic logic [DATA_W-1:0] laneMask(input logic [SEL_W-1:0] sel);
        laneMask = '0;
        for (int i = 0; i < SEL_W; i++) laneMask[i*8 +: 8] = {8{sel[i]}};
    endfunction

    assign unusedAddrBits = ^{pA_wb_addr_i[1:0], pB_wb_addr_i[1:0]};
    assign reqA = pA_wb_cyc_i & pA_wb_stb_i;
    assign reqB = pB_wb_cyc_i & pB_wb_stb_i;
    assign bankA = pA_wb_addr_i[ADDR_W-1];
    assign bankB = pB_wb_addr_i[ADDR_W-1];
    assign conflict = reqA & reqB & (bankA == bankB);
    assign prioHit = bankA ? prio1 : prio0;
    // Nothing is granted in reset, so stall simply mirrors the request there.
    assign grantA = ~wb_reset & reqA & (~conflict | ~prioHit);
    assign grantB = ~wb_reset & reqB & (~conflict | prioHit);
    assign pA_wb_stall_o = reqA & ~grantA;
    assign pB_wb_stall_o = reqB & ~grantB;

    assign useA0 = grantA & ~bankA;
    assign useB0 = grantB & ~bankB;
    assign useA1 = grantA & bankA;
    assign useB1 = grantB & bankB;
    assign weA = pA_wb_we_i ? pA_wb_sel_i : '0;
    assign weB = pB_wb_we_i ? pB_wb_sel_i : '0;
    assign waA = pA_wb_addr_i[WADDR_W+1:2];
    assign waB = pB_wb_addr_i[WADDR_W+1:2];

    assign b0_en_o = useA0 | useB0;
    assign b0_we_o = useA0 ? weA : useB0 ? weB : '0;
    assign b0_addr_o = useA0 ? waA : useB0 ? waB : '0;
    assign b0_din_o = useA0 ? pA_wb_data_i : useB0 ? pB_wb_data_i : '0;
    assign b1_en_o = useA1 | useB1;
    assign b1_we_o = useA1 ? weA : useB1 ? weB : '0;
    assign b1_addr_o = useA1 ? waA : useB1 ? waB : '0;
    assign b1_din_o = useA1 ? pA_wb_data_i : useB1 ? pB_wb_data_i : '0;

    // Gating with reset discards an ack that was already in flight.
    assign rdA = ackBankA ? b1_dout_i : b0_dout_i;
    assign rdB = ackBankB ? b1_dout_i : b0_dout_i;
    assign pA_wb_ack_o = ackA & ~wb_reset;
    assign pB_wb_ack_o = ackB & ~wb_reset;
    assign pA_wb_data_o = (pA_wb_ack_o & ~ackWeA) ? rdA & laneMask(ackSelA) : '0;
    assign pB_wb_data_o = (pB_wb_ack_o & ~ackWeB) ? rdB & laneMask(ackSelB) : '0;

    always_ff @(posedge wb_clk) begin
        if (wb_reset) begin
            ackA <= 1'b0;
            ackB <= 1'b0;
            prio0 <= 1'b0;
            prio1 <= 1'b0;
        end else begin
            ackA <= grantA;
            ackB <= grantB;
            if (conflict & ~bankA) prio0 <= ~prio0;
            if (conflict & bankA) prio1 <= ~prio1;
        end
        ackBankA <= bankA;
        ackBankB <= bankB;
        ackWeA <= pA_wb_we_i;
        ackWeB <= pB_wb_we_i;
        ackSelA <= pA_wb_sel_i;
        ackSelB <= pB_wb_sel_i;
    end
endmodule

// File: tb/tb_wb_ram_arbiter.sv
// tb_wb_ram_arbiter: scoreboard bench with a word-array memory model and a
// per-bank "whose turn" arbitration model.
module tb_wb_ram_arbiter;
    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [10:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } req_t;
    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic wb_clk = 1'b0, wb_reset = 1'b1;
    logic pA_wb_cyc_i = 0, pA_wb_stb_i = 0, pA_wb_we_i = 0;
    logic pB_wb_cyc_i = 0, pB_wb_stb_i = 0, pB_wb_we_i = 0;
    logic [10:0] pA_wb_addr_i = 0, pB_wb_addr_i = 0;
    logic [31:0] pA_wb_data_i = 0, pB_wb_data_i = 0;
    logic [3:0] pA_wb_sel_i = 0, pB_wb_sel_i = 0;
    logic pA_wb_stall_o, pA_wb_ack_o, pB_wb_stall_o, pB_wb_ack_o;
    logic [31:0] pA_wb_data_o, pB_wb_data_o;
    logic b0_en_o, b1_en_o;
    logic [3:0] b0_we_o, b1_we_o;
    logic [7:0] b0_addr_o, b1_addr_o;
    logic [31:0] b0_din_o, b1_din_o, b0_dout_i, b1_dout_i;

    logic [31:0] sram0 [256];
    logic [31:0] sram1 [256];
    logic [31:0] refMem [512];
    logic turn [2];
    exp_t q [2][$];
    int cycleNo = 0, total = 0, bad = 0;

    wb_ram_arbiter dut (
        .wb_clk(wb_clk), .wb_reset(wb_reset),
        .pA_wb_cyc_i(pA_wb_cyc_i), .pA_wb_stb_i(pA_wb_stb_i), .pA_wb_we_i(pA_wb_we_i),
        .pA_wb_addr_i(pA_wb_addr_i), .pA_wb_data_i(pA_wb_data_i), .pA_wb_sel_i(pA_wb_sel_i),
        .pA_wb_stall_o(pA_wb_stall_o), .pA_wb_ack_o(pA_wb_ack_o), .pA_wb_data_o(pA_wb_data_o),
        .pB_wb_cyc_i(pB_wb_cyc_i), .pB_wb_stb_i(pB_wb_stb_i), .pB_wb_we_i(pB_wb_we_i),
        .pB_wb_addr_i(pB_wb_addr_i), .pB_wb_data_i(pB_wb_data_i), .pB_wb_sel_i(pB_wb_sel_i),
        .pB_wb_stall_o(pB_wb_stall_o), .pB_wb_ack_o(pB_wb_ack_o), .pB_wb_data_o(pB_wb_data_o),
        .b0_en_o(b0_en_o), .b0_we_o(b0_we_o), .b0_addr_o(b0_addr_o), .b0_din_o(b0_din_o),
        .b0_dout_i(b0_dout_i),
        .b1_en_o(b1_en_o), .b1_we_o(b1_we_o), .b1_addr_o(b1_addr_o), .b1_din_o(b1_din_o),
        .b1_dout_i(b1_dout_i)
    );

    always #5 wb_clk = ~wb_clk;

    // SRAM macros: registered read of the old contents, byte-enabled write.
    always @(posedge wb_clk) begin
        if (b0_en_o) begin
            b0_dout_i <= sram0[b0_addr_o];
            for (int i = 0; i < 4; i++) if (b0_we_o[i]) sram0[b0_addr_o][i*8 +: 8] <= b0_din_o[i*8 +: 8];
        end
        if (b1_en_o) begin
            b1_dout_i <= sram1[b1_addr_o];
            for (int i = 0; i < 4; i++) if (b1_we_o[i]) sram1[b1_addr_o][i*8 +: 8] <= b1_din_o[i*8 +: 8];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cycleNo, act, exp);
        end
    endtask

    function automatic logic [31:0] bytes(input logic [3:0] sel);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = sel[i] ? 8'hff : 8'h00;
        return m;
    endfunction

    function automatic logic [31:0] modelAccess(input req_t r);
        logic [8:0] idx;
        logic [31:0] m;
        idx = {r.addr[10], r.addr[9:2]};
        m = bytes(r.sel);
        if (r.we) begin
            refMem[idx] = (refMem[idx] & ~m) | (r.data & m);
            return 32'h0;
        end
        return refMem[idx] & m;
    endfunction

    function automatic req_t mk(input logic on, input logic we, input logic [10:0] addr,
                                input logic [31:0] data, input logic [3:0] sel);
        return '{cyc: on, stb: on, we: we, addr: addr, data: data, sel: sel};
    endfunction

    task automatic step(input req_t a, input req_t b, input logic rst);
        logic rA, rB, gA, gB;
        logic [44:0] expBank [2];
        exp_t e;
        @(negedge wb_clk);
        cycleNo++;
        wb_reset = rst;
        {pA_wb_cyc_i, pA_wb_stb_i, pA_wb_we_i, pA_wb_addr_i, pA_wb_data_i, pA_wb_sel_i} = a;
        {pB_wb_cyc_i, pB_wb_stb_i, pB_wb_we_i, pB_wb_addr_i, pB_wb_data_i, pB_wb_sel_i} = b;
        #1;
        rA = a.cyc & a.stb;
        rB = b.cyc & b.stb;
        gA = 0;
        gB = 0;
        if (rst) begin
            turn[0] = 0;
            turn[1] = 0;
        end else if (rA && rB && a.addr[10] == b.addr[10]) begin
            if (turn[a.addr[10]]) gB = 1; else gA = 1;
            turn[a.addr[10]] = ~turn[a.addr[10]];
        end else begin
            gA = rA;
            gB = rB;
        end
        chk("stallA", 64'(pA_wb_stall_o), 64'(rA & ~gA));
        chk("stallB", 64'(pB_wb_stall_o), 64'(rB & ~gB));
        for (int k = 0; k < 2; k++) begin
            expBank[k] = '0;
            if (gA && a.addr[10] == k[0]) expBank[k] = {1'b1, a.we ? a.sel : 4'h0, a.addr[9:2], a.data};
            if (gB && b.addr[10] == k[0]) expBank[k] = {1'b1, b.we ? b.sel : 4'h0, b.addr[9:2], b.data};
        end
        chk("bank0", 64'({b0_en_o, b0_we_o, b0_addr_o, b0_din_o}), 64'(expBank[0]));
        chk("bank1", 64'({b1_en_o, b1_we_o, b1_addr_o, b1_din_o}), 64'(expBank[1]));
        if (gA) begin
            e.due = cycleNo + 1;
            e.data = modelAccess(a);
            q[0].push_back(e);
        end
        if (gB) begin
            e.due = cycleNo + 1;
            e.data = modelAccess(b);
            q[1].push_back(e);
        end
    endtask

    task automatic monitorPort(input int p, input logic ack, input logic [31:0] data);
        exp_t e;
        string n;
        n = p == 0 ? "A" : "B";
        if (q[p].size() > 0 && q[p][0].due == cycleNo) begin
            e = q[p].pop_front();
            if (wb_reset) begin
                chk({"ackInReset", n}, 64'(ack), 64'(0));
                chk({"dataInReset", n}, 64'(data), 64'(0));
            end else begin
                chk({"ack", n}, 64'(ack), 64'(1));
                chk({"rdata", n}, 64'(data), 64'(e.data));
            end
        end else begin
            chk({"noAck", n}, 64'(ack), 64'(0));
            chk({"idleData", n}, 64'(data), 64'(0));
        end
    endtask

    always @(negedge wb_clk) begin
        #2;
        monitorPort(0, pA_wb_ack_o, pA_wb_data_o);
        monitorPort(1, pB_wb_ack_o, pB_wb_data_o);
    end

    initial begin
        req_t idle, ra, rb;
        idle = '0;
        turn[0] = 0;
        turn[1] = 0;
        step(idle, idle, 1);
        step(mk(1, 1, 11'h000, 32'h1, 4'hf), idle, 1);
        // Fill both banks in parallel so every later read has a defined model value.
        for (int i = 0; i < 256; i++) begin
            ra = mk(1, 1, 11'(i * 4), $urandom, 4'hf);
            rb = mk(1, 1, 11'h400 | 11'(i * 4), $urandom, 4'hf);
            step(ra, rb, 0);
        end
        step(mk(1, 1, 11'h000, 32'hcafebabe, 4'hf), idle, 0);
        step(mk(1, 0, 11'h000, 32'h0, 4'hf), idle, 0);
        step(mk(1, 1, 11'h004, 32'h12345678, 4'hf), mk(1, 1, 11'h408, 32'hdeadbeef, 4'hf), 0);
        step(mk(1, 0, 11'h004, 32'h0, 4'hf), mk(1, 0, 11'h408, 32'h0, 4'hf), 0);
        for (int i = 0; i < 10; i++)
            step(mk(1, 1, 11'h004, 32'hdeadbeef, 4'hf), mk(1, 1, 11'h008, 32'hcafebabe, 4'hf), 0);
        step(mk(1, 0, 11'h004, 32'h0, 4'hf), mk(1, 0, 11'h408, 32'h0, 4'hf), 0);
        step(mk(1, 0, 11'h008, 32'h0, 4'hf), idle, 0);
        step(mk(1, 1, 11'h00c, 32'hffffffff, 4'hf), idle, 0);
        step(mk(1, 1, 11'h00c, 32'h01020304, 4'h5), idle, 0);
        step(mk(1, 0, 11'h00c, 32'h0, 4'hf), idle, 0);
        step(mk(1, 0, 11'h00c, 32'h0, 4'h2), idle, 0);
        step(mk(1, 1, 11'h010, 32'h0, 4'h0), idle, 0);
        step(mk(1, 0, 11'h010, 32'h0, 4'hf), idle, 0);
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 64; i++) begin
                ra = mk(1, 1, 11'(i * 32), 32'hffffffff - 32'(i), 4'hf);
                step(p == 0 ? ra : idle, p == 1 ? ra : idle, 0);
                ra.we = 0;
                step(p == 0 ? ra : idle, p == 1 ? ra : idle, 0);
            end
        step(mk(1, 1, 11'h020, 32'h55aa55aa, 4'hf), idle, 0);
        step(mk(1, 0, 11'h020, 32'h0, 4'hf), mk(1, 0, 11'h024, 32'h0, 4'hf), 1);
        step(mk(1, 0, 11'h020, 32'h0, 4'hf), mk(1, 0, 11'h024, 32'h0, 4'hf), 0);
        step(mk(1, 0, 11'h020, 32'h0, 4'hf), mk(1, 0, 11'h024, 32'h0, 4'hf), 0);
        for (int i = 0; i < 400; i++) begin
            ra = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom),
                  11'($urandom), 32'($urandom), 4'($urandom)};
            rb = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom),
                  11'($urandom), 32'($urandom), 4'($urandom)};
            step(ra, rb, $urandom_range(0, 49) == 0);
        end
        step(idle, idle, 0);
        step(idle, idle, 0);
        step(idle, idle, 0);
        @(negedge wb_clk);
        #3;
        chk("drain", 64'(q[0].size() + q[1].size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_ram_arbiter.md
Name: wb_ram_arbiter

Overview:
Two-port pipelined Wishbone front end that shares two single-port 32-bit SRAM banks (256 words each, 2 KiB total) between requesters A and B. Requests to different banks proceed in parallel. Requests to the same bank in the same cycle are arbitrated round-robin, and the losing port is stalled. The block sits between the two Wishbone masters and the SRAM macros, and forms the control half of the dual-port RAM.

Parameters:
ADDR_W, 11, Wishbone byte-address width; bit ADDR_W-1 selects the bank.
DATA_W, 32, data width; fixed at 32.
SEL_W, 4, byte-select width (DATA_W/8).
WADDR_W, 8, per-bank word-address width (addr[9:2]).

Ports:
wb_clk  in  1  clock; all logic on rising edge.
wb_reset  in  1  synchronous, active-high reset.
pX_wb_cyc_i  in  1  X in {A,B}: bus cycle active.
pX_wb_stb_i  in  1  request strobe; ignored unless cyc_i=1.
pX_wb_we_i  in  1  1=write, 0=read.
pX_wb_addr_i  in  ADDR_W  byte address; [1:0] ignored.
pX_wb_data_i  in  DATA_W  write data.
pX_wb_sel_i  in  SEL_W  byte lanes.
pX_wb_stall_o  out  1  request not accepted this cycle.
pX_wb_ack_o  out  1  completion, one cycle after acceptance.
pX_wb_data_o  out  DATA_W  read data, valid while ack_o=1.
bN_en_o  out  1  N in {0,1}: bank access strobe.
bN_we_o  out  SEL_W  per-byte write enable (sel & we), 0 on reads.
bN_addr_o  out  WADDR_W  word address = addr[9:2].
bN_din_o  out  DATA_W  write data.
bN_dout_i  in  DATA_W  bank read data, registered inside the macro and valid the cycle after en.

Behaviour:
- Request: reqX = cyc_i & stb_i. Target bank = addr_i[10].
- Grant (combinational):
  - Lone request: always granted.
  - Both requests to different banks: both granted.
  - Both requests to the same bank: the port indicated by that bank's priority bit prio_N is granted (0=A, 1=B).
- stall_o = reqX & ~grantX (combinational). Idle port: stall_o=0.
- Priority update: prio_N toggles only when a same-bank conflict is resolved on bank N. The loser is granted next cycle if it holds its request. No starvation.
- Bank drive:
  - Granted port drives its bank: en=1, addr, din, we = we_i ? sel_i : 0.
  - Ungranted bank: en=0, we=0. addr and din are don't-care; drive 0.
- Acceptance at edge T (grant=1) → ackX=1 during cycle T+1 for exactly one cycle.
- Back-to-back accepted requests give consecutive acks. No request is ever dropped or duplicated.
- Read data during ack = bank dout (bank registered at acceptance), with bytes whose sel bit was 0 forced to 0.
- data_o = 0 when ack_o=0. Write ack: data_o = 0.
- sel_i=0 write: bank en=1 with we=0 (no byte change), ack still issued.
- cyc_i dropped while a stall is pending: request withdrawn, no ack, prio unchanged.
- Reset:
  - During wb_reset=1: all acks 0, data_o 0, bank en/we 0, prio_0=prio_1=0 (A first).
  - stall_o = reqX while in reset.
  - Ack pending when reset asserts is discarded.
- Registered state only: ackX, ack bank select, ack sel/we capture, prio_0, prio_1. No state machine beyond this one-deep pipeline.

Test Plan:
- A writes 0xcafebabe, sel=0xF, addr 0x000 → b0_en=1, b0_we=0xF in the accept cycle, pA_ack next cycle. A reads 0x000 → pA_wb_data_o=0xcafebabe during ack.
- B writes 0xdeadbeef to 0x408 and A writes 0x12345678 to 0x004 in the same cycle → both stall_o=0, both ack next cycle. Read-back returns each value from its own bank.
- A and B both write bank 0 (0x004, 0x008), held 10 cycles → exactly one stall per cycle and exactly one ack per cycle. Grant order A,B,A,B,…; final reads 0x004=0xdeadbeef, 0x008=0xcafebabe.
- Write 0xffffffff, then write 0x01020304 with sel=0b0101 → read 0xff02ff04. Read with sel=0b0010 → 0x0000ff00.
- Sweep addr 0..0x7E0 step 32 on each port, writing 0xffffffff-i then reading back → all match. Bank split at 0x400 confirmed via bN_en_o.
- Assert wb_reset in the cycle after A is accepted → no pA_ack. Next conflict is granted to A.
